// File: rtl/periph_arb_pkg.sv
// Shared definitions for the per-slave peripheral arbiter.
// Holds default widths and the master-index width helper.
package periph_arb_pkg;

    localparam int DEF_N_MASTER   = 8;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_OUTST  = 4;

    // Bits needed to hold a master index; never less than one.
    function automatic int idx_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/periph_resp_fifo.sv
// In-order FIFO of granted master indices awaiting a response.
// Ports: i push/pop/wdata; o full/empty/head (registered head entry).
module periph_resp_fifo
    import periph_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTST,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_cnt == CW'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign head   = r_mem[r_rd];
    // A push at full is refused even if a pop happens this cycle.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/periph_slave_arb.sv
// Round-robin arbiter granting one master per cycle to a peripheral slave.
// Ports: per-master req/payload in, gnt/r_valid out; slave req/payload out,
// gnt/r_valid/rdata in; err_o flags a response arriving with nothing owed.
module periph_slave_arb
    import periph_arb_pkg::*;
#(
    parameter int N_MASTER        = DEF_N_MASTER,
    parameter int ID_WIDTH        = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTST
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    output logic [ID_WIDTH-1:0]            data_ID_o,
    input  logic                           data_gnt_i,
    input  logic                           data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    output logic                           err_o
);

    localparam int IW = idx_width(N_MASTER);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] add;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
        logic [ID_WIDTH-1:0]   id;
    } payload_t;

    logic [IW-1:0] r_rr_ptr;
    logic          r_err;
    logic [IW-1:0] w_winner;
    logic          w_found;
    logic          w_hs;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_head;
    payload_t      w_pl;

    // First requester at or after rr_ptr, wrapping past the top index.
    always_comb begin : p_scan
        int j;
        j        = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            j = int'(r_rr_ptr) + i;
            if (j >= N_MASTER) j = j - N_MASTER;
            if (!w_found && data_req_i[j]) begin
                w_found  = 1'b1;
                w_winner = IW'(j);
            end
        end
    end

    always_comb begin
        w_pl.add   = data_add_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        w_pl.wen   = data_wen_i[w_winner];
        w_pl.wdata = data_wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
        w_pl.be    = data_be_i[int'(w_winner)*BE_WIDTH +: BE_WIDTH];
        w_pl.id    = data_ID_i[int'(w_winner)*ID_WIDTH +: ID_WIDTH];
    end

    assign data_req_o     = w_found & ~w_full;
    assign data_add_o     = w_pl.add;
    assign data_wen_o     = w_pl.wen;
    assign data_wdata_o   = w_pl.wdata;
    assign data_be_o      = w_pl.be;
    assign data_ID_o      = w_pl.id;
    assign data_r_rdata_o = data_r_rdata_i;
    assign err_o          = r_err;

    assign w_hs  = data_req_o & data_gnt_i;
    assign w_pop = data_r_valid_i & ~w_empty;

    always_comb begin
        data_gnt_o     = '0;
        data_r_valid_o = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            data_gnt_o[m]     = w_hs & (w_winner == IW'(m));
            data_r_valid_o[m] = w_pop & (w_head == IW'(m));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= (w_winner == IW'(N_MASTER - 1)) ?
                            '0 : w_winner + 1'b1;
            end
            if (data_r_valid_i & w_empty) r_err <= 1'b1;
        end
    end

    periph_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_hs),
        .pop   (w_pop),
        .wdata (w_winner),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

endmodule

// File: tb/tb_periph_slave_arb.sv
// Directed bench for periph_slave_arb: grants, ordering, backpressure,
// response routing and error flag, with hand-computed expectations.
module tb_periph_slave_arb;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IDW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] add_i;
    logic [N-1:0]    wen_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*BW-1:0] be_i;
    logic [N*IDW-1:0] id_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            req_o;
    logic [AW-1:0]   add_o;
    logic            wen_o;
    logic [DW-1:0]   wdata_o;
    logic [BW-1:0]   be_o;
    logic [IDW-1:0]  id_o;
    logic            gnt_i;
    logic            rvalid_i;
    logic [DW-1:0]   rdata_i;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    periph_slave_arb dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (req_i),
        .data_add_i     (add_i),
        .data_wen_i     (wen_i),
        .data_wdata_i   (wdata_i),
        .data_be_i      (be_i),
        .data_ID_i      (id_i),
        .data_gnt_o     (gnt_o),
        .data_r_valid_o (rvalid_o),
        .data_r_rdata_o (rdata_o),
        .data_req_o     (req_o),
        .data_add_o     (add_o),
        .data_wen_o     (wen_o),
        .data_wdata_o   (wdata_o),
        .data_be_o      (be_o),
        .data_ID_o      (id_o),
        .data_gnt_i     (gnt_i),
        .data_r_valid_i (rvalid_i),
        .data_r_rdata_i (rdata_i),
        .err_o          (err_o)
    );

    function automatic logic [AW-1:0] addr_of(input int m);
        if (m == 3) return 32'h1A10_0000;
        return 32'h1000_0000 + 32'(m) * 32'h100;
    endfunction

    // Inputs change just after the falling edge, checks follow 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b want 0", req_o);
        end
        checks++;
        if (gnt_o !== 8'h00 || rvalid_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_gnt_rv got %h/%h want 00/00", gnt_o, rvalid_o);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err_o);
        end
    endtask

    task automatic test_single();
        step();
        req_i = 8'h08;
        gnt_i = 1'b1;
        #1;
        checks++;
        if (req_o !== 1'b1 || gnt_o !== 8'h08) begin
            errors++;
            $display("FAIL single_gnt got req=%b gnt=%h want 1/08", req_o, gnt_o);
        end
        checks++;
        if (add_o !== 32'h1A10_0000 || id_o !== 8'h33 || wen_o !== 1'b1) begin
            errors++;
            $display("FAIL single_payload got %h/%h/%b want 1a100000/33/1",
                     add_o, id_o, wen_o);
        end
        step();
        req_i = '0;
        gnt_i = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 8'h00) begin
            errors++;
            $display("FAIL single_early_rv got %h want 00", rvalid_o);
        end
        step();
        rvalid_i = 1'b1;
        rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rvalid_o !== 8'h08 || rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_resp got %h/%h want 08/deadbeef",
                     rvalid_o, rdata_o);
        end
        step();
        rvalid_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_m [6] = '{0, 2, 5, 0, 2, 5};
        logic [N-1:0] exp_rv;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            req_i = 8'b0010_0101;
            gnt_i = 1'b1;
            rvalid_i = (k > 0);
            #1;
            exp_rv = (k > 0) ? (8'h01 << exp_m[(k > 0) ? k - 1 : 0]) : 8'h00;
            checks++;
            if (gnt_o !== (8'h01 << exp_m[k]) || rvalid_o !== exp_rv ||
                add_o !== addr_of(exp_m[k])) begin
                errors++;
                $display("FAIL rr_%0d got gnt=%h rv=%h add=%h want %h/%h/%h", k,
                         gnt_o, rvalid_o, add_o, 8'h01 << exp_m[k], exp_rv,
                         addr_of(exp_m[k]));
            end
        end
        step();
        req_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h20) begin
            errors++;
            $display("FAIL rr_last_resp got %h want 20", rvalid_o);
        end
        step();
        rvalid_i = 1'b0;
    endtask

    task automatic test_full();
        logic [N-1:0] exp_g [4] = '{8'h02, 8'h40, 8'h02, 8'h40};
        logic [N-1:0] exp_r [4] = '{8'h40, 8'h02, 8'h40, 8'h02};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            req_i = 8'b0100_0010;
            gnt_i = 1'b1;
            #1;
            checks++;
            if (gnt_o !== exp_g[k]) begin
                errors++;
                $display("FAIL full_fill_%0d got %h want %h", k, gnt_o, exp_g[k]);
            end
        end
        step();
        #1;
        checks++;
        if (req_o !== 1'b0 || gnt_o !== 8'h00) begin
            errors++;
            $display("FAIL full_block got req=%b gnt=%h want 0/00", req_o, gnt_o);
        end
        step();
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h02 || req_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop got rv=%h req=%b want 02/0", rvalid_o, req_o);
        end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (req_o !== 1'b1 || gnt_o !== 8'h02) begin
            errors++;
            $display("FAIL full_refill got req=%b gnt=%h want 1/02", req_o, gnt_o);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            req_i = '0;
            gnt_i = 1'b0;
            rvalid_i = 1'b1;
            #1;
            checks++;
            if (rvalid_o !== exp_r[k]) begin
                errors++;
                $display("FAIL full_drain_%0d got %h want %h", k, rvalid_o, exp_r[k]);
            end
        end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL full_no_err got %b want 0", err_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            req_i = 8'h02;
            gnt_i = 1'b0;
            #1;
            checks++;
            if (req_o !== 1'b1 || gnt_o !== 8'h00 || add_o !== addr_of(1) ||
                id_o !== 8'h31) begin
                errors++;
                $display("FAIL stall_%0d got req=%b gnt=%h add=%h id=%h", k,
                         req_o, gnt_o, add_o, id_o);
            end
        end
        step();
        req_i = 8'h03;
        gnt_i = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 8'h01) begin
            errors++;
            $display("FAIL stall_ptr got %h want 01", gnt_o);
        end
        step();
        req_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h01) begin
            errors++;
            $display("FAIL stall_resp got %h want 01", rvalid_o);
        end
        step();
        rvalid_i = 1'b0;
    endtask

    task automatic test_err();
        step();
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h00 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_same got rv=%h err=%b want 00/0", rvalid_o, err_o);
        end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", err_o);
        end
        step();
        step();
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err_o);
        end
        do_reset();
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        req_i = 8'h0C;
        gnt_i = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 8'h04) begin
            errors++;
            $display("FAIL mid_g0 got %h want 04", gnt_o);
        end
        step();
        #1;
        checks++;
        if (gnt_o !== 8'h08) begin
            errors++;
            $display("FAIL mid_g1 got %h want 08", gnt_o);
        end
        do_reset();
        step();
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h00) begin
            errors++;
            $display("FAIL mid_stale got %h want 00", rvalid_o);
        end
        step();
        rvalid_i = 1'b0;
        req_i = 8'h21;
        gnt_i = 1'b1;
        #1;
        checks++;
        if (err_o !== 1'b1 || gnt_o !== 8'h01) begin
            errors++;
            $display("FAIL mid_ptr got err=%b gnt=%h want 1/01", err_o, gnt_o);
        end
        step();
        req_i = 8'h80;
        #1;
        checks++;
        if (gnt_o !== 8'h80 || id_o !== 8'h37) begin
            errors++;
            $display("FAIL mid_m7 got gnt=%h id=%h want 80/37", gnt_o, id_o);
        end
        step();
        req_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 8'h01) begin
            errors++;
            $display("FAIL mid_r0 got %h want 01", rvalid_o);
        end
        step();
        #1;
        checks++;
        if (rvalid_o !== 8'h80) begin
            errors++;
            $display("FAIL mid_r1 got %h want 80", rvalid_o);
        end
        step();
        rvalid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b0;
        rdata_i = '0;
        for (int m = 0; m < N; m++) begin
            add_i[m*AW +: AW]   = addr_of(m);
            wen_i[m]            = m[0];
            wdata_i[m*DW +: DW] = 32'hA000_0000 + 32'(m);
            be_i[m*BW +: BW]    = 4'(m + 1);
            id_i[m*IDW +: IDW]  = 8'h30 + 8'(m);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_stall();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
